// File: rtl/output_handler.sv
// Serialises a WORDS x 32-bit digest to a UART one byte at a time, MSB byte first.
// Define OUTPUT_HANDLER_HEX_EN to send each byte as two lowercase ASCII hex characters plus a trailing 0x0A.
module output_handler #(
  parameter int unsigned WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        word_req,
  input  logic        word_valid,
  input  logic [31:0] word_in,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WIW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIW-1:0] LAST_WORD = WIW'(WORDS - 1);

`ifdef OUTPUT_HANDLER_HEX_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT_WORD, SEND, GUARD, DRAIN, TERM, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT_WORD, SEND, GUARD, DRAIN, FIN} state_t;
`endif

  state_t         state, state_nxt;
  logic [31:0]    shreg;
  logic [1:0]     byte_idx;
  logic [WIW-1:0] word_idx;
  logic           last_byte, last_word;

`ifdef OUTPUT_HANDLER_HEX_EN
  logic nib;
  logic term_sent;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h57 + 8'(n));
  endfunction
`endif

  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (word_idx == LAST_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    word_req  = 1'b0;
    transmit  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE) && (state != FIN);
    case (state)
      IDLE:      if (start) state_nxt = REQ;
      REQ: begin
        word_req  = 1'b1;
        state_nxt = WAIT_WORD;
      end
      WAIT_WORD: if (word_valid) state_nxt = SEND;
      SEND: begin
        transmit  = 1'b1;
        state_nxt = GUARD;
      end
      // UART status lags transmit by a cycle, so this state never looks at it
      GUARD:     state_nxt = DRAIN;
      DRAIN: begin
        if (!is_transmitting) begin
`ifdef OUTPUT_HANDLER_HEX_EN
          if (term_sent)       state_nxt = FIN;
          else if (!nib)       state_nxt = SEND;
          else if (!last_byte) state_nxt = SEND;
          else if (!last_word) state_nxt = REQ;
          else                 state_nxt = TERM;
`else
          if (!last_byte)      state_nxt = SEND;
          else if (!last_word) state_nxt = REQ;
          else                 state_nxt = FIN;
`endif
        end
      end
`ifdef OUTPUT_HANDLER_HEX_EN
      TERM: begin
        transmit  = 1'b1;
        state_nxt = GUARD;
      end
`endif
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // tx_byte is loaded on the edge entering SEND/TERM so it is valid with transmit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      tx_byte   <= '0;
`ifdef OUTPUT_HANDLER_HEX_EN
      nib       <= 1'b0;
      term_sent <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_idx  <= '0;
`ifdef OUTPUT_HANDLER_HEX_EN
            nib       <= 1'b0;
            term_sent <= 1'b0;
`endif
          end
        end
        WAIT_WORD: begin
          if (word_valid) begin
            shreg    <= word_in;
            byte_idx <= '0;
`ifdef OUTPUT_HANDLER_HEX_EN
            nib      <= 1'b0;
            tx_byte  <= hex_char(word_in[31:28]);
`else
            tx_byte  <= word_in[31:24];
`endif
          end
        end
        DRAIN: begin
          if (!is_transmitting) begin
`ifdef OUTPUT_HANDLER_HEX_EN
            if (term_sent) begin
              // terminator already out; FIN follows
            end else if (!nib) begin
              nib     <= 1'b1;
              tx_byte <= hex_char(shreg[27:24]);
            end else begin
              nib <= 1'b0;
              if (!last_byte) begin
                shreg    <= {shreg[23:0], 8'h00};
                byte_idx <= byte_idx + 2'd1;
                tx_byte  <= hex_char(shreg[23:20]);
              end else if (!last_word) begin
                word_idx <= word_idx + WIW'(1);
              end else begin
                tx_byte   <= 8'h0A;
                term_sent <= 1'b1;
              end
            end
`else
            if (!last_byte) begin
              shreg    <= {shreg[23:0], 8'h00};
              byte_idx <= byte_idx + 2'd1;
              tx_byte  <= shreg[23:16];
            end else if (!last_word) begin
              word_idx <= word_idx + WIW'(1);
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
